// File: rtl/t09_mode_sequencer.sv
// Mode sequencer: steps a registered mode forward/backward on button edges, with load, lock and change/wrap pulses.
// Define T09_MODESEQ_AUTOREPEAT_EN to build the hold-to-repeat counter.
module t09_mode_sequencer #(
    parameter int NUM_MODES     = 3,
    parameter int MODE_W        = 2,
    parameter int RESET_MODE    = 1,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next,
    input  logic              prev,
    input  logic              load,
    input  logic [MODE_W-1:0] load_mode,
    input  logic              lock,
    output logic [MODE_W-1:0] mode,
    output logic              mode_changed,
    output logic              wrapped
);

    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] INIT_MODE = MODE_W'(RESET_MODE);

    if (NUM_MODES < 2 || (2 ** MODE_W) < NUM_MODES || RESET_MODE >= NUM_MODES ||
        HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("t09_mode_sequencer: illegal parameter combination");
    end

    function automatic logic [MODE_W-1:0] step_fwd(input logic [MODE_W-1:0] m);
        return (m == LAST_MODE) ? '0 : m + MODE_W'(1);
    endfunction

    function automatic logic [MODE_W-1:0] step_bwd(input logic [MODE_W-1:0] m);
        return (m == '0) ? LAST_MODE : m - MODE_W'(1);
    endfunction

    logic              next_q, prev_q;
    logic              next_edge, prev_edge, edge_step;
    logic              fwd_req, bwd_req;
    logic [MODE_W-1:0] mode_nxt;
    logic              changed_nxt, wrapped_nxt;

    assign next_edge = next & ~next_q;
    assign prev_edge = prev & ~prev_q;
    // Simultaneous edges cancel; load and lock both discard edges.
    assign edge_step = (next_edge ^ prev_edge) & ~load & ~lock;

`ifdef T09_MODESEQ_AUTOREPEAT_EN
    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic             rpt_act, rpt_dir, rpt_fast;
    logic [CNT_W-1:0] rpt_cnt, rpt_thr;
    logic             hold_ok, rpt_run, rpt_fire;

    // rpt_dir: 0 = repeating next, 1 = repeating prev
    assign hold_ok  = rpt_dir ? (prev & ~next) : (next & ~prev);
    assign rpt_run  = rpt_act & hold_ok & ~load & ~lock;
    assign rpt_thr  = rpt_fast ? CNT_W'(REPEAT_CYCLES) : CNT_W'(HOLD_CYCLES);
    assign rpt_fire = rpt_run & (rpt_cnt == rpt_thr);

    // rpt_cnt counts cycles since the last step taken in this hold
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_act  <= 1'b0;
            rpt_dir  <= 1'b0;
            rpt_fast <= 1'b0;
            rpt_cnt  <= '0;
        end else if (edge_step) begin
            rpt_act  <= 1'b1;
            rpt_dir  <= prev_edge;
            rpt_fast <= 1'b0;
            rpt_cnt  <= CNT_W'(1);
        end else if (rpt_run) begin
            if (rpt_fire) begin
                rpt_fast <= 1'b1;
                rpt_cnt  <= CNT_W'(1);
            end else begin
                rpt_cnt  <= rpt_cnt + CNT_W'(1);
            end
        end else begin
            rpt_act  <= 1'b0;
            rpt_fast <= 1'b0;
            rpt_cnt  <= '0;
        end
    end

    assign fwd_req = (edge_step & next_edge) | (rpt_fire & ~rpt_dir);
    assign bwd_req = (edge_step & prev_edge) | (rpt_fire & rpt_dir);
`else
    assign fwd_req = edge_step & next_edge;
    assign bwd_req = edge_step & prev_edge;
`endif

    always_comb begin
        mode_nxt    = mode;
        changed_nxt = 1'b0;
        wrapped_nxt = 1'b0;
        if (load) begin
            if (load_mode <= LAST_MODE && load_mode != mode) begin
                mode_nxt    = load_mode;
                changed_nxt = 1'b1;
            end
        end else if (fwd_req) begin
            mode_nxt    = step_fwd(mode);
            changed_nxt = 1'b1;
            wrapped_nxt = (mode == LAST_MODE);
        end else if (bwd_req) begin
            mode_nxt    = step_bwd(mode);
            changed_nxt = 1'b1;
            wrapped_nxt = (mode == '0);
        end
    end

    // History set to 1 on reset so a button held through reset release is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            next_q       <= 1'b1;
            prev_q       <= 1'b1;
            mode         <= INIT_MODE;
            mode_changed <= 1'b0;
            wrapped      <= 1'b0;
        end else begin
            next_q       <= next;
            prev_q       <= prev;
            mode         <= mode_nxt;
            mode_changed <= changed_nxt;
            wrapped      <= wrapped_nxt;
        end
    end

endmodule

// File: tb/tb_t09_mode_sequencer.sv
// Directed bench for t09_mode_sequencer (default parameters); auto-repeat expectations follow T09_MODESEQ_AUTOREPEAT_EN.
module tb_t09_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst, next, prev, load, lock;
    logic [1:0] load_mode;
    logic [1:0] mode;
    logic       mode_changed, wrapped;

    int errors = 0;
    int checks = 0;

    t09_mode_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .next         (next),
        .prev         (prev),
        .load         (load),
        .load_mode    (load_mode),
        .lock         (lock),
        .mode         (mode),
        .mode_changed (mode_changed),
        .wrapped      (wrapped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int m, input int c, input int w);
        chk({tag, ".mode"}, 32'(mode), m);
        chk({tag, ".changed"}, 32'(mode_changed), c);
        chk({tag, ".wrapped"}, 32'(wrapped), w);
    endtask

    initial begin
        int exp_mode[4];
        int exp_wrap[4];
        int pulses;
        int m;
        exp_mode = '{2, 0, 1, 2};
        exp_wrap = '{0, 1, 0, 0};

        rst = 1'b1; next = 1'b0; prev = 1'b0; load = 1'b0; lock = 1'b0; load_mode = 2'd0;
        tick();
        tick();
        chk3("reset", 1, 0, 0);
        rst = 1'b0;
        tick();
        chk3("idle", 1, 0, 0);

        // forward sequence 1,2,0,1,2 with one wrap
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            next = 1'b1;
            tick();
            chk3("fwd_step", exp_mode[i], 1, exp_wrap[i]);
            pulses += int'(mode_changed);
            next = 1'b0;
            tick();
            chk3("fwd_gap", exp_mode[i], 0, 0);
            pulses += int'(mode_changed);
        end
        chk("fwd_pulse_count", 32'(pulses), 4);

        // to mode 0, then backward wrap to 2
        next = 1'b1; tick(); chk3("to_zero", 0, 1, 1);
        next = 1'b0; tick();
        prev = 1'b1; tick(); chk3("bwd_wrap", 2, 1, 1);
        prev = 1'b0; tick(); chk3("bwd_gap", 2, 0, 0);
        next = 1'b1; prev = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk3("both_cancel", 2, 0, 0);
        end
        next = 1'b0; prev = 1'b0; tick();

        // load beats a step edge; out-of-range and same-value loads are ignored
        load = 1'b1; load_mode = 2'd0; next = 1'b1;
        tick(); chk3("load0_with_edge", 0, 1, 0);
        load = 1'b0; next = 1'b0; tick(); chk3("after_load0", 0, 0, 0);
        load = 1'b1; load_mode = 2'd2; next = 1'b1;
        tick(); chk3("load2_with_edge", 2, 1, 0);
        next = 1'b0; tick(); chk3("load_same", 2, 0, 0);
        load_mode = 2'd3; tick(); chk3("load_oor", 2, 0, 0);
        load = 1'b0; tick(); chk3("after_oor", 2, 0, 0);

        // lock discards edges and does not replay them
        lock = 1'b1;
        next = 1'b1; tick(); chk3("lock_p1", 2, 0, 0);
        next = 1'b0; tick();
        next = 1'b1; tick(); chk3("lock_p2", 2, 0, 0);
        next = 1'b0; tick();
        next = 1'b1; tick();
        lock = 1'b0; tick(); chk3("unlock_held", 2, 0, 0);
        tick(); chk3("unlock_held2", 2, 0, 0);
        next = 1'b0; tick();
        next = 1'b1; tick(); chk3("unlock_step", 0, 1, 1);
        next = 1'b0; tick();

        // next held across reset release gives no step
        next = 1'b1; rst = 1'b1; tick(); chk3("rst_held", 1, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk3("held_after_rst", 1, 0, 0);
        end
        next = 1'b0; tick();

        // 20-cycle hold from mode 1
        next = 1'b1; tick(); chk3("hold_edge", 2, 1, 0);
        m = 2;
        for (int j = 1; j < 20; j++) begin
            tick();
`ifdef T09_MODESEQ_AUTOREPEAT_EN
            if (j == 8 || j == 12 || j == 16) begin
                m = (m == 2) ? 0 : m + 1;
                chk3("hold_repeat", m, 1, (j == 8) ? 1 : 0);
            end else begin
                chk3("hold_wait", m, 0, 0);
            end
`else
            chk3("hold_single", m, 0, 0);
`endif
        end

        // reset mid-hold returns to mode 1 and no repeat follows
        rst = 1'b1; tick(); chk3("rst_mid_hold", 1, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk3("post_rst_hold", 1, 0, 0);
        end
        next = 1'b0; tick(); chk3("release", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
